serializer_sched: RTL
=====================

Name: serializer_sched

Overview:
- Round-robin scheduler sharing the single 8-bit serializer input between NUM_CHANNELS requesters.
- Builds one frame per pass: each channel gets at most one grant per frame.
- Closes the frame with ser_last when every channel has been served, or with a ser_flush pulse after TIMEOUT idle cycles, so the serializer can emit its footer.
- Sits directly upstream of the serializer, between the channel front-ends and serializer din.

Parameters:
- NUM_CHANNELS, 16, number of requesters; must be ≥2.
- DATA_W, 8, sample width.
- TIMEOUT, 16, idle cycles inside a frame before forced flush; must be ≥1.
- CH_W (localparam), $clog2(NUM_CHANNELS), channel index width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_CHANNELS  per-channel sample-pending, level.
- data  in  NUM_CHANNELS*DATA_W  packed samples; channel i at [i*DATA_W +: DATA_W].
- gnt  out  NUM_CHANNELS  one-hot, combinational; sample taken this cycle; requester drops or updates req next cycle.
- ser_din  out  DATA_W  registered sample to serializer.
- ser_valid  out  1  ser_din holds a word.
- ser_ready  in  1  serializer accepts word when ser_valid & ser_ready.
- ser_last  out  1  qualifies ser_din as the final word of a full frame.
- ser_flush  out  1  one-cycle pulse: close a partial frame.
- busy  out  1  high while in COLLECT or FLUSH.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ser_din=0; ser_valid=0; ser_last=0; ser_flush=0; gnt=0; busy=0; served mask=0; rr_ptr=0; idle counter=0.
- States: IDLE, COLLECT, FLUSH.
- IDLE: any req → COLLECT in the same cycle, with a grant allowed that cycle.
- Grant condition (COLLECT, or IDLE with req): slot free, i.e. !ser_valid | ser_ready.
  - Winner: first channel at or after rr_ptr (wrapping modulo NUM_CHANNELS) with req=1 and served=0.
  - gnt=onehot(winner).
  - Next edge: ser_din←data[winner]; ser_valid←1; served[winner]←1; rr_ptr←winner+1 mod NUM_CHANNELS; idle counter←0.
- Latency: gnt cycle N → word on ser_din at cycle N+1. Back-to-back grants sustain 1 word/cycle with ser_ready=1.
- Slot free, no grant: ser_valid←0.
- Backpressure: ser_valid=1 and ser_ready=0:
  - ser_din, ser_valid, ser_last held.
  - gnt=0.
  - idle counter frozen.
- Full frame: the grant that sets the final served bit registers ser_last=1 with that word.
  - On handshake of that word: served←0, state←IDLE.
  - ser_last stays high only while that word is valid.
- Timeout: in COLLECT, idle counter increments each cycle with no grant and no stall.
  - Counter reaches TIMEOUT → FLUSH.
  - FLUSH waits until ser_valid=0 (last word drained), then pulses ser_flush for 1 cycle → IDLE, served←0. rr_ptr is kept.
- Simultaneous events:
  - Counter hitting TIMEOUT in the same cycle as a new req: timeout wins, gnt=0; the request is served in the next frame.
  - A served channel keeps requesting: ignored until the frame closes.
  - ser_flush and ser_last never assert together.
  - A frame with zero words never flushes.
- Reset mid-frame: all state cleared immediately. A word in flight is dropped; the serializer is reset together with this block.

Optional Feature:
- SERIALIZER_SCHED_STATS_EN defined: adds output ports frames_full[15:0] and frames_flushed[15:0].
  - Saturating counters, incremented on the ser_last handshake and on the ser_flush pulse respectively.
  - Reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package serializer_pkg: NUM_CHANNELS, DATA_W, default TIMEOUT, state encoding (IDLE/COLLECT/FLUSH), CH_W helper. The serializer also imports it.
- One sub-module: rr_pick — combinational masked round-robin priority selector.
  - Inputs: req & ~served, rr_ptr.
  - Outputs: one-hot gnt, winner index, any.

Test Plan:
- Partial frame: rst_n low 20 ns, ser_ready=1; req ch0..3 with A1,B2,C3,D4 → ser_din A1,B2,C3,D4 on consecutive cycles, no ser_last; 16 idle cycles later one ser_flush pulse; busy then 0.
- Full frame: all 16 req with random data → 16 words in channel order 0..15; ser_last only on word 16; no ser_flush; served clears.
- Backpressure: ser_ready=0 for 3 cycles after word 5 → word 5 held stable, gnt=0, no timeout; resumes with word 6.
- Fairness: ch5 req held high, ch9 req pulsed → ch5 granted once per frame; next frame starts search at rr_ptr=6 and grants ch9 before ch5.
- Timeout race: new req arrives exactly on the TIMEOUT cycle → gnt=0, ser_flush, that channel granted first in the next frame.
- Reset mid-frame after 7 words → all outputs 0 asynchronously; next frame starts at ch0 with empty served mask.

Source files
------------

// File: rtl/serializer_pkg.sv
// serializer_pkg: constants and state encoding shared by the round-robin
// scheduler and the serializer it feeds.
package serializer_pkg;

    localparam int SER_NUM_CHANNELS = 16;
    localparam int SER_DATA_W       = 8;
    localparam int SER_TIMEOUT      = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2
    } sched_state_t;

    // Channel index width; never below one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serializer_sched_rr_pick.sv
// rr_pick: combinational masked round-robin selector. Returns the first
// requester at or after ptr (wrapping), as one-hot and as an index.
module rr_pick
    import serializer_pkg::*;
#(
    parameter int NUM_CHANNELS = SER_NUM_CHANNELS,
    parameter int CH_W         = ch_w(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0] req,
    input  logic [CH_W-1:0]         ptr,
    output logic [NUM_CHANNELS-1:0] gnt,
    output logic [CH_W-1:0]         idx,
    output logic                    hit
);

    // Scan from the farthest offset back towards ptr so the nearest requester is written last.
    always_comb begin
        int c;
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        c   = 0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            c = (int'(ptr) + i) % NUM_CHANNELS;
            if (req[CH_W'(c)]) begin
                idx = CH_W'(c);
                hit = 1'b1;
            end
        end
        if (hit) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/serializer_sched.sv
// serializer_sched: round-robin scheduler that shares the serializer input
// between NUM_CHANNELS requesters. Each channel gets at most one word per
// frame; a frame closes with ser_last once every channel is served, or with
// a ser_flush pulse after TIMEOUT idle cycles.
// Optional: define SERIALIZER_SCHED_STATS_EN to add saturating frame counters
// frames_full / frames_flushed.
module serializer_sched
    import serializer_pkg::*;
#(
    parameter int NUM_CHANNELS = SER_NUM_CHANNELS,
    parameter int DATA_W       = SER_DATA_W,
    parameter int TIMEOUT      = SER_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CHANNELS-1:0]        req,
    input  logic [NUM_CHANNELS*DATA_W-1:0] data,
    output logic [NUM_CHANNELS-1:0]        gnt,
    output logic [DATA_W-1:0]              ser_din,
    output logic                           ser_valid,
    input  logic                           ser_ready,
    output logic                           ser_last,
    output logic                           ser_flush,
    output logic                           busy
`ifdef SERIALIZER_SCHED_STATS_EN
    ,
    output logic [15:0]                    frames_full,
    output logic [15:0]                    frames_flushed
`endif
);

    localparam int CH_W  = ch_w(NUM_CHANNELS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sched_state_t            state, state_nxt;
    logic [NUM_CHANNELS-1:0] served;
    logic [NUM_CHANNELS-1:0] pick_gnt;
    logic [CH_W-1:0]         rr_ptr;
    logic [CH_W-1:0]         win;
    logic                    hit;
    logic                    slot_free;
    logic                    grant_ok;
    logic                    take;
    logic                    last_hs;
    logic                    timed_out;
    logic                    close_frame;
    logic [CNT_W-1:0]        idle_cnt;

    assign slot_free = ~ser_valid | ser_ready;
    assign last_hs   = ser_valid & ser_ready & ser_last;
    assign timed_out = (idle_cnt == CNT_W'(TIMEOUT));

    rr_pick #(
        .NUM_CHANNELS(NUM_CHANNELS),
        .CH_W        (CH_W)
    ) u_pick (
        .req(req & ~served),
        .ptr(rr_ptr),
        .gnt(pick_gnt),
        .idx(win),
        .hit(hit)
    );

    // Next state, grant qualification and the one-cycle flush pulse.
    always_comb begin
        state_nxt = state;
        grant_ok  = 1'b0;
        ser_flush = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = COLLECT;
                    grant_ok  = slot_free;
                end
            end
            COLLECT: begin
                // Timeout beats a late request: that request waits for the next frame.
                if (timed_out) begin
                    state_nxt = FLUSH;
                end else begin
                    grant_ok = slot_free;
                    if (last_hs) state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (!ser_valid) begin
                    ser_flush = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The grant is gated by rst_n so it is low for the whole reset, even with requests pending.
    assign take        = grant_ok & hit & rst_n;
    assign gnt         = take ? pick_gnt : '0;
    assign close_frame = (state != IDLE) && (state_nxt == IDLE);
    assign busy        = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Output word register: load on grant, hold under backpressure, empty when the slot frees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_din   <= '0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else if (take) begin
            ser_din   <= data[int'(win)*DATA_W +: DATA_W];
            ser_valid <= 1'b1;
            ser_last  <= &(served | pick_gnt);
        end else if (slot_free) begin
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end
    end

    // Frame bookkeeping: served mask, round-robin pointer and idle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            served   <= '0;
            rr_ptr   <= '0;
            idle_cnt <= '0;
        end else begin
            if (take) begin
                served   <= served | pick_gnt;
                rr_ptr   <= (win == CH_W'(NUM_CHANNELS - 1)) ? '0 : win + 1'b1;
                idle_cnt <= '0;
            end else if (state == COLLECT && slot_free && !timed_out) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (close_frame) begin
                served   <= '0;
                idle_cnt <= '0;
            end
        end
    end

`ifdef SERIALIZER_SCHED_STATS_EN
    // Saturating counts of frames closed by ser_last and by ser_flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_full    <= '0;
            frames_flushed <= '0;
        end else begin
            if (last_hs && frames_full != 16'hFFFF)      frames_full    <= frames_full + 16'd1;
            if (ser_flush && frames_flushed != 16'hFFFF) frames_flushed <= frames_flushed + 16'd1;
        end
    end
`endif

endmodule
